decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Sits directly downstream of Fetch.
- Contains the F-to-D pipeline register, the 15-entry 64-bit register file with its write-back port, and the Decode combinational logic: source/destination selection plus the forwarding mux.
- Outputs feed the Execute pipeline register.
- Fetch also consumes D_icode, D_rA and D_rB for its stall checks.

Parameters:
- RSP_INIT, 64'd0, reset value of register 4 (%rsp); all other registers reset to 0.

Ports:
- clk  in  1  system clock, rising-edge active
- rst  in  1  asynchronous, active-high reset
- f_icode, f_ifun, f_rA, f_rB  in  4 each  fetched fields
- f_valC, f_valP  in  64 each  fetched constant / next PC
- f_stat  in  2  fetch status: 00 AOK, 01 HLT, 10 ADR, 11 INS
- D_stall  in  1  hold the D register
- D_bubble  in  1  load a nop into the D register
- e_dstE  in  4, e_valE  in  64  Execute-stage result; dstE is already forced to F when a cmov fails
- M_dstE, M_dstM  in  4 each; M_valE, m_valM  in  64 each  Memory-stage results
- W_dstE, W_dstM  in  4 each; W_valE, W_valM  in  64 each  write-back values, also forwarding sources
- D_icode, D_ifun, D_rA, D_rB  out  4 each  registered fields
- D_valC, D_valP  out  64 each; D_stat  out  2  registered values
- d_srcA, d_srcB, d_dstE, d_dstM  out  4 each  decoded register IDs
- d_valA, d_valB  out  64 each  forwarded operands

Behaviour:
- Register ID 4'hF means "none" everywhere.

D register:
- While rst is high: asynchronous clear to bubble state, i.e. icode 0, ifun 0, rA F, rB F, valC 0, valP 0, stat 00.
- On a rising clock edge:
  - If D_stall: hold all fields.
  - Else if D_bubble: load bubble state.
  - Else: load the f_* inputs.
- D_stall has priority when both D_stall and D_bubble are asserted.

Source/destination decode (combinational on D_*; icode values: 2 cmov, 3 irmov, 4 rmmov, 5 mrmov, 6 OP, 7 jxx, 8 call, 9 ret, A push, B pop):
- d_srcA:
  - D_rA for icode 2, 4, 6, A
  - 4 for icode 9, B
  - else F
- d_srcB:
  - D_rB for icode 4, 5, 6
  - 4 for icode 8, 9, A, B
  - else F
- d_dstE:
  - D_rB for icode 2, 3, 6
  - 4 for icode 8, 9, A, B
  - else F
- d_dstM:
  - D_rA for icode 5, B
  - else F
- Any unlisted icode (0, 1, invalid) yields all four IDs = F.

Register file:
- 15 x 64 bits, IDs 0-14.
- Reads are combinational; reading ID F returns 0.
- Write on the rising edge:
  - If W_dstE != F: write W_valE to reg[W_dstE].
  - If W_dstM != F: write W_valM to reg[W_dstM].
  - If W_dstE == W_dstM (not F), W_valM wins.
- Writes to ID F are ignored.
- rst asynchronously sets every register to 0, except register 4, which takes RSP_INIT.
- rst asserted mid-operation takes effect immediately, without waiting for a clock edge.

d_valA selection, in priority order:
1. D_valP, if D_icode is 7 or 8.
2. e_valE, if d_srcA == e_dstE.
3. m_valM, if d_srcA == M_dstM.
4. M_valE, if d_srcA == M_dstE.
5. W_valM, if d_srcA == W_dstM.
6. W_valE, if d_srcA == W_dstE.
7. Otherwise the register file value.
- Any match against ID F is suppressed: when d_srcA == F, the result is 0 unless the D_valP rule applies.

d_valB:
- Same priority chain on d_srcB, without the D_valP rule.

General timing:
- All d_* outputs are combinational, with zero-cycle latency from the D register and the forwarding inputs.
- D_* outputs change only on a clock edge or on rst.
- Same-cycle write-back and read of the same register returns the W value via forwarding, never the stale register-file contents.

Test Plan:
- Reset: pulse rst with clk idle -> D_icode 0, D_rA F, D_stat 00, reg4 == RSP_INIT, other registers 0; d_valA 0.
- Load and decode: f = OPq (icode 6, ifun 0) rA 2, rB 3; W writes reg2 = 5, reg3 = 7 beforehand; clock -> d_srcA 2, d_srcB 3, d_dstE 3, d_dstM F, d_valA 5, d_valB 7.
- Forwarding priority: d_srcA 2 with e_dstE 2/e_valE 11, M_dstM 2/m_valM 22, W_dstE 2/W_valE 33 -> d_valA 11. Drop e_dstE to F -> 22. Drop M_dstM to F -> 33.
- Stall vs bubble: load a call (icode 8, valP 0x40); next cycle D_stall = 1 and D_bubble = 1 with new f inputs -> D_* unchanged, d_valA 0x40, d_srcB 4. Then D_bubble only -> D_icode 0, all d_ IDs F.
- Dual write conflict: W_dstE = W_dstM = 6, W_valE 1, W_valM 2, clock; then decode rmmov (icode 4) with rA 6 and no forwarding active -> d_valA 2. Also W_dstE F with W_valE 99 -> no register changes.
- Async reset mid-run: assert rst between clock edges after several writes -> all outputs and registers immediately return to reset values; first edge after rst is released loads f_* normally.

Source files
------------

// File: rtl/decode_stage_if.sv
// decode_stage_if: Fetch/Decode/Execute/Memory/Write-back signals seen by the decode stage
interface decode_stage_if;
  logic [3:0] f_icode, f_ifun, f_rA, f_rB;
  logic [63:0] f_valC, f_valP;
  logic [1:0] f_stat;
  logic D_stall, D_bubble;
  logic [3:0] e_dstE;
  logic [63:0] e_valE;
  logic [3:0] M_dstE, M_dstM;
  logic [63:0] M_valE, m_valM;
  logic [3:0] W_dstE, W_dstM;
  logic [63:0] W_valE, W_valM;
  logic [3:0] D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic [1:0] D_stat;
  logic [3:0] d_srcA, d_srcB, d_dstE, d_dstM;
  logic [63:0] d_valA, d_valB;
  modport master (
    output f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, f_stat, D_stall, D_bubble,
    output e_dstE, e_valE, M_dstE, M_dstM, M_valE, m_valM, W_dstE, W_dstM, W_valE, W_valM,
    input D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, D_stat,
    input d_srcA, d_srcB, d_dstE, d_dstM, d_valA, d_valB
  );
  modport slave (
    input f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, f_stat, D_stall, D_bubble,
    input e_dstE, e_valE, M_dstE, M_dstM, M_valE, m_valM, W_dstE, W_dstM, W_valE, W_valM,
    output D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, D_stat,
    output d_srcA, d_srcB, d_dstE, d_dstM, d_valA, d_valB
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: F-to-D pipeline register, 15x64 register file and operand forwarding
module decode_stage #(
  parameter logic [63:0] RSP_INIT = 64'd0
) (
  input logic clk,
  input logic rst,
  decode_stage_if.slave bus
);
  localparam logic [3:0] NONE = 4'hF;
  localparam logic [3:0] RSP = 4'h4;
  logic [63:0] rf [15];
  // D register: stall holds, bubble injects a nop, otherwise capture Fetch
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.D_icode <= 4'h0;
      bus.D_ifun <= 4'h0;
      bus.D_rA <= NONE;
      bus.D_rB <= NONE;
      bus.D_valC <= 64'd0;
      bus.D_valP <= 64'd0;
      bus.D_stat <= 2'b00;
    end else if (!bus.D_stall) begin
      bus.D_icode <= bus.D_bubble ? 4'h0 : bus.f_icode;
      bus.D_ifun <= bus.D_bubble ? 4'h0 : bus.f_ifun;
      bus.D_rA <= bus.D_bubble ? NONE : bus.f_rA;
      bus.D_rB <= bus.D_bubble ? NONE : bus.f_rB;
      bus.D_valC <= bus.D_bubble ? 64'd0 : bus.f_valC;
      bus.D_valP <= bus.D_bubble ? 64'd0 : bus.f_valP;
      bus.D_stat <= bus.D_bubble ? 2'b00 : bus.f_stat;
    end
  // register file write-back; the M port is written last so it wins a same-ID collision
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < 15; i++) rf[i] <= (i == 4) ? RSP_INIT : 64'd0;
    end else begin
      if (bus.W_dstE != NONE) rf[bus.W_dstE] <= bus.W_valE;
      if (bus.W_dstM != NONE) rf[bus.W_dstM] <= bus.W_valM;
    end
  // register ID decode and forwarding, youngest producer first
  always_comb begin
    bus.d_srcA = bus.D_icode inside {4'h2, 4'h4, 4'h6, 4'hA} ? bus.D_rA
               : bus.D_icode inside {4'h9, 4'hB} ? RSP : NONE;
    bus.d_srcB = bus.D_icode inside {4'h4, 4'h5, 4'h6} ? bus.D_rB
               : bus.D_icode inside {4'h8, 4'h9, 4'hA, 4'hB} ? RSP : NONE;
    bus.d_dstE = bus.D_icode inside {4'h2, 4'h3, 4'h6} ? bus.D_rB
               : bus.D_icode inside {4'h8, 4'h9, 4'hA, 4'hB} ? RSP : NONE;
    bus.d_dstM = bus.D_icode inside {4'h5, 4'hB} ? bus.D_rA : NONE;
    bus.d_valA = bus.D_icode inside {4'h7, 4'h8} ? bus.D_valP
               : bus.d_srcA == NONE ? 64'd0
               : bus.d_srcA == bus.e_dstE ? bus.e_valE
               : bus.d_srcA == bus.M_dstM ? bus.m_valM
               : bus.d_srcA == bus.M_dstE ? bus.M_valE
               : bus.d_srcA == bus.W_dstM ? bus.W_valM
               : bus.d_srcA == bus.W_dstE ? bus.W_valE
               : rf[bus.d_srcA];
    bus.d_valB = bus.d_srcB == NONE ? 64'd0
               : bus.d_srcB == bus.e_dstE ? bus.e_valE
               : bus.d_srcB == bus.M_dstM ? bus.m_valM
               : bus.d_srcB == bus.M_dstE ? bus.M_valE
               : bus.d_srcB == bus.W_dstM ? bus.W_valM
               : bus.d_srcB == bus.W_dstE ? bus.W_valE
               : rf[bus.d_srcB];
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a behavioural model
module tb_decode_stage;
  localparam logic [63:0] RSP = 64'h0000_0000_0000_0F00;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  decode_stage_if bus();
  decode_stage #(.RSP_INIT(RSP)) dut (.clk(clk), .rst(rst), .bus(bus));
  int passed = 0;
  int total = 0;
  logic [63:0] mrf [15];
  logic [3:0] m_icode, m_ifun, m_rA, m_rB;
  logic [63:0] m_valC, m_valP;
  logic [1:0] m_stat;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    {m_icode, m_ifun, m_rA, m_rB, m_valC, m_valP, m_stat} = {4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 2'd0};
    for (int i = 0; i < 15; i++) mrf[i] = (i == 4) ? RSP : 64'd0;
  endtask

  function automatic logic [3:0] x_srcA();
    case (m_icode)
      4'h2, 4'h4, 4'h6, 4'hA: return m_rA;
      4'h9, 4'hB: return 4'h4;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [3:0] x_srcB();
    case (m_icode)
      4'h4, 4'h5, 4'h6: return m_rB;
      4'h8, 4'h9, 4'hA, 4'hB: return 4'h4;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [3:0] x_dstE();
    case (m_icode)
      4'h2, 4'h3, 4'h6: return m_rB;
      4'h8, 4'h9, 4'hA, 4'hB: return 4'h4;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [3:0] x_dstM();
    return (m_icode == 4'h5 || m_icode == 4'hB) ? m_rA : 4'hF;
  endfunction

  function automatic logic [63:0] x_fwd(input logic [3:0] s);
    logic [3:0] ids [5];
    logic [63:0] vals [5];
    ids = '{bus.e_dstE, bus.M_dstM, bus.M_dstE, bus.W_dstM, bus.W_dstE};
    vals = '{bus.e_valE, bus.m_valM, bus.M_valE, bus.W_valM, bus.W_valE};
    if (s == 4'hF) return 64'd0;
    for (int i = 0; i < 5; i++) if (ids[i] == s) return vals[i];
    return mrf[s];
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".D_icode"}, 64'(bus.D_icode), 64'(m_icode));
    chk({tag, ".D_ifun"}, 64'(bus.D_ifun), 64'(m_ifun));
    chk({tag, ".D_rA"}, 64'(bus.D_rA), 64'(m_rA));
    chk({tag, ".D_rB"}, 64'(bus.D_rB), 64'(m_rB));
    chk({tag, ".D_valC"}, bus.D_valC, m_valC);
    chk({tag, ".D_valP"}, bus.D_valP, m_valP);
    chk({tag, ".D_stat"}, 64'(bus.D_stat), 64'(m_stat));
    chk({tag, ".d_srcA"}, 64'(bus.d_srcA), 64'(x_srcA()));
    chk({tag, ".d_srcB"}, 64'(bus.d_srcB), 64'(x_srcB()));
    chk({tag, ".d_dstE"}, 64'(bus.d_dstE), 64'(x_dstE()));
    chk({tag, ".d_dstM"}, 64'(bus.d_dstM), 64'(x_dstM()));
    chk({tag, ".d_valA"}, bus.d_valA, (m_icode == 4'h7 || m_icode == 4'h8) ? m_valP : x_fwd(x_srcA()));
    chk({tag, ".d_valB"}, bus.d_valB, x_fwd(x_srcB()));
  endtask

  task automatic idle_fwd();
    {bus.e_dstE, bus.M_dstE, bus.M_dstM, bus.W_dstE, bus.W_dstM} = {5{4'hF}};
    {bus.e_valE, bus.M_valE, bus.m_valM, bus.W_valE, bus.W_valM} = '0;
  endtask

  task automatic set_f(input logic [3:0] ic, input logic [3:0] rA, input logic [3:0] rB, input logic [63:0] vp);
    bus.f_icode = ic;
    bus.f_ifun = 4'h0;
    bus.f_rA = rA;
    bus.f_rB = rB;
    bus.f_valC = 64'h1234;
    bus.f_valP = vp;
    bus.f_stat = 2'b00;
  endtask

  task automatic step();
    if (!bus.D_stall) begin
      if (bus.D_bubble) {m_icode, m_ifun, m_rA, m_rB, m_valC, m_valP, m_stat} = {4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 2'd0};
      else {m_icode, m_ifun, m_rA, m_rB, m_valC, m_valP, m_stat} =
        {bus.f_icode, bus.f_ifun, bus.f_rA, bus.f_rB, bus.f_valC, bus.f_valP, bus.f_stat};
    end
    if (bus.W_dstE != 4'hF) mrf[bus.W_dstE] = bus.W_valE;
    if (bus.W_dstM != 4'hF) mrf[bus.W_dstM] = bus.W_valM;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] rnd_id();
    return ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 7));
  endfunction

  initial begin
    idle_fwd();
    set_f(4'h1, 4'hF, 4'hF, 64'd0);
    bus.D_stall = 1'b0;
    bus.D_bubble = 1'b0;
    #1 rst = 1'b1;
    model_reset();
    #1;
    check_all("reset");
    chk("reset.d_valA", bus.d_valA, 64'd0);
    @(negedge clk) rst = 1'b0;
    set_f(4'hA, 4'h0, 4'hF, 64'd0);
    step();
    check_all("rst_regs");
    chk("rst_regs.rsp", bus.d_valB, RSP);
    set_f(4'h6, 4'h2, 4'h3, 64'h8);
    bus.W_dstE = 4'h2; bus.W_valE = 64'd5;
    bus.W_dstM = 4'h3; bus.W_valM = 64'd7;
    step();
    idle_fwd();
    #1;
    check_all("op");
    chk("op.valA", bus.d_valA, 64'd5);
    chk("op.valB", bus.d_valB, 64'd7);
    bus.e_dstE = 4'h2; bus.e_valE = 64'd11;
    bus.M_dstM = 4'h2; bus.m_valM = 64'd22;
    bus.W_dstE = 4'h2; bus.W_valE = 64'd33;
    #1 chk("fwd.e", bus.d_valA, 64'd11);
    bus.e_dstE = 4'hF;
    #1 chk("fwd.m", bus.d_valA, 64'd22);
    bus.M_dstM = 4'hF;
    #1 chk("fwd.w", bus.d_valA, 64'd33);
    idle_fwd();
    set_f(4'h8, 4'hF, 4'hF, 64'h40);
    step();
    set_f(4'h6, 4'h1, 4'h5, 64'h99);
    bus.D_stall = 1'b1;
    bus.D_bubble = 1'b1;
    step();
    check_all("stall");
    chk("stall.icode", 64'(bus.D_icode), 64'h8);
    chk("stall.valA", bus.d_valA, 64'h40);
    chk("stall.srcB", 64'(bus.d_srcB), 64'h4);
    bus.D_stall = 1'b0;
    step();
    bus.D_bubble = 1'b0;
    check_all("bubble");
    chk("bubble.icode", 64'(bus.D_icode), 64'h0);
    chk("bubble.ids", {48'd0, bus.d_srcA, bus.d_srcB, bus.d_dstE, bus.d_dstM}, 64'hFFFF);
    set_f(4'h4, 4'h6, 4'hF, 64'h50);
    bus.W_dstE = 4'h6; bus.W_valE = 64'd1;
    bus.W_dstM = 4'h6; bus.W_valM = 64'd2;
    step();
    idle_fwd();
    #1;
    check_all("dual");
    chk("dual.valA", bus.d_valA, 64'd2);
    bus.W_valE = 64'd99;
    step();
    check_all("nowrite");
    chk("nowrite.valA", bus.d_valA, 64'd2);
    for (int n = 0; n < 200; n++) begin
      bus.f_icode = 4'($urandom_range(0, 15));
      bus.f_ifun = 4'($urandom_range(0, 15));
      bus.f_rA = rnd_id();
      bus.f_rB = rnd_id();
      bus.f_valC = {$urandom(), $urandom()};
      bus.f_valP = {$urandom(), $urandom()};
      bus.f_stat = 2'($urandom_range(0, 3));
      bus.D_stall = ($urandom_range(0, 7) == 0);
      bus.D_bubble = ($urandom_range(0, 7) == 0);
      step();
      bus.e_dstE = rnd_id(); bus.e_valE = {$urandom(), $urandom()};
      bus.M_dstE = rnd_id(); bus.M_valE = {$urandom(), $urandom()};
      bus.M_dstM = rnd_id(); bus.m_valM = {$urandom(), $urandom()};
      bus.W_dstE = rnd_id(); bus.W_valE = {$urandom(), $urandom()};
      bus.W_dstM = rnd_id(); bus.W_valM = {$urandom(), $urandom()};
      #1;
      check_all($sformatf("rnd%0d", n));
    end
    bus.D_stall = 1'b0;
    bus.D_bubble = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_all("async");
    chk("async.d_valA", bus.d_valA, 64'd0);
    idle_fwd();
    set_f(4'hA, 4'h6, 4'hF, 64'h60);
    @(negedge clk) rst = 1'b0;
    step();
    check_all("post_rst");
    chk("post_rst.icode", 64'(bus.D_icode), 64'hA);
    chk("post_rst.reg6", bus.d_valA, 64'd0);
    chk("post_rst.rsp", bus.d_valB, RSP);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
